// File: rtl/avalon_burst_arbiter.sv
// rtl/avalon_burst_arbiter.sv - two-master Avalon-MM burst arbiter
// Grants the shared slave port for a whole transaction: every write beat, or one read command plus all its data beats.
module avalon_burst_arbiter #(
  parameter bit CPU_PRIORITY = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  input  logic [2:0]  m0_burstcount,
  input  logic        m0_write,
  input  logic        m0_read,
  output logic        m0_waitrequest,
  output logic        m0_readdatavalid,
  output logic [31:0] m0_readdata,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  input  logic [2:0]  m1_burstcount,
  input  logic        m1_write,
  input  logic        m1_read,
  output logic        m1_waitrequest,
  output logic        m1_readdatavalid,
  output logic [31:0] m1_readdata,
  output logic [31:0] s_address,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  output logic [2:0]  s_burstcount,
  output logic        s_write,
  output logic        s_read,
  input  logic        s_waitrequest,
  input  logic        s_readdatavalid,
  input  logic [31:0] s_readdata
);
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} state_t;

  state_t     state;
  logic       owner;
  logic       last_owner;
  logic       cmd_done;
  logic [2:0] beat_cnt;
  logic [2:0] rd_len;

  logic       o_write;
  logic       o_read;
  logic [2:0] o_len;
  logic [2:0] cur_len;
  logic [2:0] beat_next;
  logic       req0;
  logic       req1;
  logic       gnt;
  logic       active;
  logic       wr_acc;
  logic       rd_acc;

  // A zero burstcount means a single beat; anything above 4 is clamped so beat_cnt cannot wrap.
  function automatic logic [2:0] eff_len(input logic [2:0] bc);
    if (bc == 3'd0) return 3'd1;
    if (bc > 3'd4) return 3'd4;
    return bc;
  endfunction

  assign o_write      = owner ? m1_write : m0_write;
  assign o_read       = owner ? m1_read : m0_read;
  assign s_address    = owner ? m1_address : m0_address;
  assign s_writedata  = owner ? m1_writedata : m0_writedata;
  assign s_byteenable = owner ? m1_byteenable : m0_byteenable;
  assign s_burstcount = owner ? m1_burstcount : m0_burstcount;

  assign active  = (state != IDLE);
  assign s_write = (state == WRITE) && o_write;
  assign s_read  = (state == READ) && o_read && !cmd_done;

  assign m0_waitrequest   = (active && !owner) ? s_waitrequest : 1'b1;
  assign m1_waitrequest   = (active && owner) ? s_waitrequest : 1'b1;
  assign m0_readdatavalid = (state == READ) && !owner && s_readdatavalid;
  assign m1_readdatavalid = (state == READ) && owner && s_readdatavalid;
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;

  // On a tie m1 wins only in round-robin mode when m0 held the last grant.
  assign req0 = m0_write | m0_read;
  assign req1 = m1_write | m1_read;
  assign gnt  = req1 && (!req0 || (CPU_PRIORITY ? 1'b0 : !last_owner));

  assign wr_acc    = s_write && !s_waitrequest;
  assign rd_acc    = s_read && !s_waitrequest;
  assign o_len     = eff_len(s_burstcount);
  assign cur_len   = rd_acc ? o_len : rd_len;
  assign beat_next = (beat_cnt == 3'd4) ? beat_cnt : beat_cnt + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      beat_cnt   <= 3'd0;
      cmd_done   <= 1'b0;
      rd_len     <= 3'd1;
    end else begin
      case (state)
        IDLE: begin
          cmd_done <= 1'b0;
          if (req0 || req1) begin
            owner      <= gnt;
            last_owner <= gnt;
            beat_cnt   <= 3'd0;
            rd_len     <= eff_len(gnt ? m1_burstcount : m0_burstcount);
            state      <= (gnt ? m1_write : m0_write) ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_acc) begin
            beat_cnt <= beat_next;
            if (beat_next == o_len) state <= IDLE;
          end
        end
        READ: begin
          if (rd_acc) begin
            cmd_done <= 1'b1;
            rd_len   <= o_len;
          end
          if (s_readdatavalid) begin
            beat_cnt <= beat_next;
            if (beat_next == cur_len) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_avalon_burst_arbiter.sv
// tb/tb_avalon_burst_arbiter.sv - self-checking bench for avalon_burst_arbiter
// Two instances (CPU priority and round-robin) share stimulus; sel picks which one is observed.
`timescale 1ns/1ps
module tb_avalon_burst_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] m_address [2];
  logic [31:0] m_writedata [2];
  logic [3:0]  m_byteenable [2];
  logic [2:0]  m_burstcount [2];
  logic        m_write [2];
  logic        m_read [2];
  logic        s_waitrequest, s_readdatavalid;
  logic [31:0] s_readdata;

  logic [1:0]  wt_p, wt_r, rv_p, rv_r;
  logic [31:0] rd0_p, rd1_p, rd0_r, rd1_r, sa_p, sa_r, sd_p, sd_r;
  logic [3:0]  sb_p, sb_r;
  logic [2:0]  sc_p, sc_r;
  logic        sw_p, sw_r, sr_p, sr_r;

  bit          sel;
  logic [1:0]  wt, rv;
  logic [31:0] rd0, rd1, sa, sd;
  logic [3:0]  sb;
  logic [2:0]  sc;
  logic        sw, sr;
  assign wt  = sel ? wt_r : wt_p;
  assign rv  = sel ? rv_r : rv_p;
  assign rd0 = sel ? rd0_r : rd0_p;
  assign rd1 = sel ? rd1_r : rd1_p;
  assign sa  = sel ? sa_r : sa_p;
  assign sd  = sel ? sd_r : sd_p;
  assign sb  = sel ? sb_r : sb_p;
  assign sc  = sel ? sc_r : sc_p;
  assign sw  = sel ? sw_r : sw_p;
  assign sr  = sel ? sr_r : sr_p;

  avalon_burst_arbiter #(.CPU_PRIORITY(1'b1)) dut_p (
    .clk(clk), .rst_n(rst_n),
    .m0_address(m_address[0]), .m0_writedata(m_writedata[0]), .m0_byteenable(m_byteenable[0]),
    .m0_burstcount(m_burstcount[0]), .m0_write(m_write[0]), .m0_read(m_read[0]),
    .m0_waitrequest(wt_p[0]), .m0_readdatavalid(rv_p[0]), .m0_readdata(rd0_p),
    .m1_address(m_address[1]), .m1_writedata(m_writedata[1]), .m1_byteenable(m_byteenable[1]),
    .m1_burstcount(m_burstcount[1]), .m1_write(m_write[1]), .m1_read(m_read[1]),
    .m1_waitrequest(wt_p[1]), .m1_readdatavalid(rv_p[1]), .m1_readdata(rd1_p),
    .s_address(sa_p), .s_writedata(sd_p), .s_byteenable(sb_p), .s_burstcount(sc_p),
    .s_write(sw_p), .s_read(sr_p), .s_waitrequest(s_waitrequest),
    .s_readdatavalid(s_readdatavalid), .s_readdata(s_readdata)
  );

  avalon_burst_arbiter #(.CPU_PRIORITY(1'b0)) dut_r (
    .clk(clk), .rst_n(rst_n),
    .m0_address(m_address[0]), .m0_writedata(m_writedata[0]), .m0_byteenable(m_byteenable[0]),
    .m0_burstcount(m_burstcount[0]), .m0_write(m_write[0]), .m0_read(m_read[0]),
    .m0_waitrequest(wt_r[0]), .m0_readdatavalid(rv_r[0]), .m0_readdata(rd0_r),
    .m1_address(m_address[1]), .m1_writedata(m_writedata[1]), .m1_byteenable(m_byteenable[1]),
    .m1_burstcount(m_burstcount[1]), .m1_write(m_write[1]), .m1_read(m_read[1]),
    .m1_waitrequest(wt_r[1]), .m1_readdatavalid(rv_r[1]), .m1_readdata(rd1_r),
    .s_address(sa_r), .s_writedata(sd_r), .s_byteenable(sb_r), .s_burstcount(sc_r),
    .s_write(sw_r), .s_read(sr_r), .s_waitrequest(s_waitrequest),
    .s_readdatavalid(s_readdatavalid), .s_readdata(s_readdata)
  );

  int n_chk = 0, n_fail = 0, cyc = 0;

  // master agents
  bit mg_act [2], mg_wr [2], mg_cmd [2], acc_now [2];
  int mg_bc [2], mg_done [2], mg_got [2], n_iss [2], n_cpl [2];
  bit auto_req;
  // slave agent
  int sl_pend, rdv_mode;
  bit rdv_tog, stall_rand;
  bit stall_q [$];
  // event stamps and counters
  int first_wbeat [2], last_wbeat [2], cmd_cyc [2], last_rdv [2], n_rdv [2];
  int n_sw, n_acc_w;
  // transaction-level reference: who owns the port and how many beats remain
  bit md_busy, md_owner, md_last, md_rd, md_cmd;
  int md_left;

  function automatic int eff(input int bc);
    return (bc == 0) ? 1 : ((bc > 4) ? 4 : bc);
  endfunction

  task automatic start(input int n, input bit wr, input int bc);
    mg_act[n] = 1; mg_wr[n] = wr; mg_bc[n] = bc; mg_done[n] = 0; mg_got[n] = 0; mg_cmd[n] = 0;
    n_iss[n]++;
    m_address[n] = $urandom() & 32'hFFFF_FFFC;
    m_writedata[n] = $urandom();
    m_byteenable[n] = 4'($urandom());
    m_burstcount[n] = 3'(bc);
    m_write[n] = wr;
    m_read[n] = !wr;
  endtask

  task automatic clear_stamps();
    for (int n = 0; n < 2; n++) begin
      first_wbeat[n] = -1; last_wbeat[n] = -1; cmd_cyc[n] = -1; last_rdv[n] = -1;
    end
  endtask

  // One clock: sample and compare at posedge+2, then drive the next inputs at posedge+1.
  task automatic tick();
    logic o, w, r0, r1;
    logic e_wt [2];
    logic e_rv [2];
    logic e_sw, e_sr;
    #1;
    if (!rst_n) begin md_busy = 0; md_owner = 0; md_last = 1; md_cmd = 0; end
    o = md_owner;
    e_wt[0] = 1; e_wt[1] = 1; e_rv[0] = 0; e_rv[1] = 0; e_sw = 0; e_sr = 0;
    if (md_busy) begin
      e_wt[o] = s_waitrequest;
      e_rv[o] = md_rd & s_readdatavalid;
      e_sw = !md_rd & m_write[o];
      e_sr = md_rd & !md_cmd & m_read[o];
    end
    n_chk++;
    if ({wt, sw, sr, rv} !== {e_wt[1], e_wt[0], e_sw, e_sr, e_rv[1], e_rv[0]}) begin
      n_fail++;
      $display("FAIL ctl sel=%0d cyc=%0d got wt/sw/sr/rv=%b expected=%b", sel, cyc,
               {wt, sw, sr, rv}, {e_wt[1], e_wt[0], e_sw, e_sr, e_rv[1], e_rv[0]});
    end
    if (md_busy) begin
      n_chk++;
      if ({sa, sd, sb, sc} !== {m_address[o], m_writedata[o], m_byteenable[o], m_burstcount[o]}) begin
        n_fail++;
        $display("FAIL slave_mux sel=%0d cyc=%0d got=%h expected=%h", sel, cyc, {sa, sd, sb, sc},
                 {m_address[o], m_writedata[o], m_byteenable[o], m_burstcount[o]});
      end
    end
    n_chk++;
    if ({rd0, rd1} !== {s_readdata, s_readdata}) begin
      n_fail++;
      $display("FAIL readdata cyc=%0d got=%h expected=%h", cyc, {rd0, rd1}, {s_readdata, s_readdata});
    end

    for (int n = 0; n < 2; n++) begin
      acc_now[n] = 0;
      if (mg_act[n] && mg_wr[n] && m_write[n] && !wt[n]) begin
        mg_done[n]++; acc_now[n] = 1; last_wbeat[n] = cyc;
        if (first_wbeat[n] < 0) first_wbeat[n] = cyc;
      end
      if (mg_act[n] && !mg_wr[n] && m_read[n] && !wt[n] && !mg_cmd[n]) begin
        mg_cmd[n] = 1; cmd_cyc[n] = cyc;
      end
      if (rv[n]) begin
        n_rdv[n]++; last_rdv[n] = cyc;
        if (mg_act[n] && !mg_wr[n]) mg_got[n]++;
      end
    end
    if (sw) n_sw++;
    if (sw && !s_waitrequest) n_acc_w++;
    if (sr && !s_waitrequest) sl_pend += eff(int'(sc));
    if (s_readdatavalid && sl_pend > 0) sl_pend--;

    if (rst_n) begin
      r0 = m_write[0] | m_read[0];
      r1 = m_write[1] | m_read[1];
      if (!md_busy) begin
        if (r0 || r1) begin
          w = (r0 && r1) ? ((sel == 0) ? 1'b0 : !md_last) : r1;
          md_busy = 1; md_owner = w; md_last = w; md_rd = !m_write[w]; md_cmd = 0;
          md_left = eff(int'(m_burstcount[w]));
        end
      end else if (!md_rd) begin
        if (m_write[o] && !s_waitrequest) begin
          md_left--;
          if (md_left == 0) md_busy = 0;
        end
      end else begin
        if (m_read[o] && !md_cmd && !s_waitrequest) md_cmd = 1;
        if (s_readdatavalid) begin
          md_left--;
          if (md_left == 0) md_busy = 0;
        end
      end
    end

    @(posedge clk);
    #1;
    cyc++;
    for (int n = 0; n < 2; n++) begin
      if (mg_act[n]) begin
        if (mg_wr[n]) begin
          if (mg_done[n] == eff(mg_bc[n])) begin
            mg_act[n] = 0; m_write[n] = 0; n_cpl[n]++;
          end else if (acc_now[n]) m_writedata[n] = $urandom();
        end else begin
          if (mg_cmd[n]) m_read[n] = 0;
          if (mg_got[n] == eff(mg_bc[n])) begin
            mg_act[n] = 0; n_cpl[n]++;
          end
        end
      end else if (auto_req && $urandom_range(0, 3) == 0) begin
        start(n, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
      end
    end
    if (stall_q.size() > 0) s_waitrequest = stall_q.pop_front();
    else s_waitrequest = stall_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    s_readdatavalid = 0;
    if (sl_pend > 0) begin
      case (rdv_mode)
        0: s_readdatavalid = 1'($urandom_range(0, 1));
        1: s_readdatavalid = 1;
        default: begin s_readdatavalid = rdv_tog; rdv_tog = !rdv_tog; end
      endcase
    end
    s_readdata = $urandom();
  endtask

  task automatic run_idle(input int bound, output bit done);
    for (int k = 0; k < bound && (mg_act[0] || mg_act[1]); k++) tick();
    done = !(mg_act[0] || mg_act[1]);
  endtask

  task automatic do_reset(input bit s);
    sel = s; rst_n = 0; auto_req = 0; stall_rand = 0; rdv_mode = 1; rdv_tog = 1;
    sl_pend = 0; stall_q.delete();
    for (int n = 0; n < 2; n++) begin
      mg_act[n] = 0; m_write[n] = 0; m_read[n] = 0; n_iss[n] = 0; n_cpl[n] = 0;
    end
    tick(); tick();
    rst_n = 1;
    tick();
    clear_stamps();
  endtask

  task automatic test_reset();
    rst_n = 0; m_write[0] = 1; m_read[1] = 1;
    #1;
    n_chk++;
    if ({wt_p, sw_p, sr_p, rv_p, wt_r, sw_r, sr_r, rv_r} !== 12'b110000_110000) begin
      n_fail++; $display("FAIL reset_values got=%b expected=%b",
                         {wt_p, sw_p, sr_p, rv_p, wt_r, sw_r, sr_r, rv_r}, 12'b110000_110000);
    end
    @(posedge clk); #2;
    n_chk++;
    if ({wt_p, sw_p, sr_p, rv_p, wt_r, sw_r, sr_r, rv_r} !== 12'b110000_110000) begin
      n_fail++; $display("FAIL reset_held got=%b expected=%b",
                         {wt_p, sw_p, sr_p, rv_p, wt_r, sw_r, sr_r, rv_r}, 12'b110000_110000);
    end
    m_write[0] = 0; m_read[1] = 0;
    @(posedge clk); #1;
    do_reset(0);
  endtask

  task automatic test_solo_write();
    int c0, s0;
    bit done;
    do_reset(0);
    c0 = cyc; s0 = n_sw;
    start(0, 1, 4);
    run_idle(30, done);
    tick();
    n_chk++;
    if (!done) begin n_fail++; $display("FAIL solo_write_timeout got=busy expected=idle"); end
    n_chk++;
    if (n_sw - s0 != 4) begin n_fail++; $display("FAIL solo_write_cycles got=%0d expected=4", n_sw - s0); end
    n_chk++;
    if (first_wbeat[0] - c0 != 1 || last_wbeat[0] - c0 != 4) begin
      n_fail++; $display("FAIL solo_write_timing got=%0d..%0d expected=1..4", first_wbeat[0] - c0, last_wbeat[0] - c0);
    end
  endtask

  task automatic test_read_stall();
    int c0, r0, r1;
    bit done;
    do_reset(0);
    rdv_mode = 2; rdv_tog = 1;
    c0 = cyc; r0 = n_rdv[0]; r1 = n_rdv[1];
    start(0, 0, 3);
    stall_q.push_back(1); stall_q.push_back(1); stall_q.push_back(0);
    run_idle(40, done);
    n_chk++;
    if (!done) begin n_fail++; $display("FAIL read_stall_timeout got=busy expected=idle"); end
    n_chk++;
    if (cmd_cyc[0] - c0 != 3) begin n_fail++; $display("FAIL read_stall_cmd got=%0d expected=3", cmd_cyc[0] - c0); end
    n_chk++;
    if (n_rdv[0] - r0 != 3 || n_rdv[1] - r1 != 0) begin
      n_fail++; $display("FAIL read_stall_beats got=%0d/%0d expected=3/0", n_rdv[0] - r0, n_rdv[1] - r1);
    end
    n_chk++;
    if (last_rdv[0] - c0 != 8) begin n_fail++; $display("FAIL read_stall_last got=%0d expected=8", last_rdv[0] - c0); end
  endtask

  task automatic test_tie(input bit s);
    int c0;
    bit done;
    do_reset(s);
    start(0, 1, 1);
    run_idle(20, done);
    tick(); tick();
    clear_stamps();
    c0 = cyc;
    start(0, 0, 2);
    start(1, 1, 4);
    run_idle(100, done);
    n_chk++;
    if (!done) begin n_fail++; $display("FAIL tie_timeout sel=%0d got=busy expected=idle", s); end
    if (s) begin
      n_chk++;
      if (last_wbeat[1] - c0 != 4) begin n_fail++; $display("FAIL rr_m1_first got=%0d expected=4", last_wbeat[1] - c0); end
      n_chk++;
      if (cmd_cyc[0] != last_wbeat[1] + 2) begin
        n_fail++; $display("FAIL rr_m0_grant got=%0d expected=%0d", cmd_cyc[0], last_wbeat[1] + 2);
      end
    end else begin
      n_chk++;
      if (cmd_cyc[0] - c0 != 1) begin n_fail++; $display("FAIL prio_m0_first got=%0d expected=1", cmd_cyc[0] - c0); end
      n_chk++;
      if (first_wbeat[1] != last_rdv[0] + 2) begin
        n_fail++; $display("FAIL prio_m1_wait got=%0d expected=%0d", first_wbeat[1], last_rdv[0] + 2);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int k, v0, g1;
    bit done;
    do_reset(0);
    start(0, 0, 4);
    for (k = 0; k < 30 && mg_got[0] < 2; k++) tick();
    n_chk++;
    if (mg_got[0] != 2) begin n_fail++; $display("FAIL midrst_beats got=%0d expected=2", mg_got[0]); end
    v0 = n_rdv[0] + n_rdv[1];
    rst_n = 0; mg_act[0] = 0; m_read[0] = 0;
    tick();
    rst_n = 1;
    tick(); tick();
    n_chk++;
    if (n_rdv[0] + n_rdv[1] != v0) begin
      n_fail++; $display("FAIL midrst_late_rdv got=%0d expected=0", n_rdv[0] + n_rdv[1] - v0);
    end
    g1 = n_rdv[1];
    start(1, 0, 2);
    run_idle(30, done);
    n_chk++;
    if (!done || n_rdv[1] - g1 != 2) begin
      n_fail++; $display("FAIL midrst_next_read got=%0d beats done=%0d expected=2 beats done=1", n_rdv[1] - g1, done);
    end
  endtask

  task automatic test_write_stall_single();
    int c0, a0;
    bit done;
    do_reset(0);
    c0 = cyc; a0 = n_acc_w;
    start(0, 1, 1);
    stall_q.push_back(1); stall_q.push_back(0);
    run_idle(20, done);
    tick(); tick();
    n_chk++;
    if (!done || n_acc_w - a0 != 1) begin
      n_fail++; $display("FAIL wr1_beats got=%0d done=%0d expected=1 done=1", n_acc_w - a0, done);
    end
    n_chk++;
    if (last_wbeat[0] - c0 != 2) begin n_fail++; $display("FAIL wr1_timing got=%0d expected=2", last_wbeat[0] - c0); end
  endtask

  task automatic test_random(input bit s);
    bit done;
    do_reset(s);
    stall_rand = 1; rdv_mode = 0; auto_req = 1;
    repeat (600) tick();
    auto_req = 0;
    run_idle(300, done);
    n_chk++;
    if (!done) begin n_fail++; $display("FAIL random_drain sel=%0d got=busy expected=idle", s); end
    n_chk++;
    if (n_cpl[0] != n_iss[0] || n_cpl[1] != n_iss[1]) begin
      n_fail++; $display("FAIL random_complete sel=%0d got=%0d/%0d expected=%0d/%0d", s,
                         n_cpl[0], n_cpl[1], n_iss[0], n_iss[1]);
    end
  endtask

  initial begin
    rst_n = 0; sel = 0;
    for (int n = 0; n < 2; n++) begin
      m_address[n] = '0; m_writedata[n] = '0; m_byteenable[n] = '0; m_burstcount[n] = '0;
      m_write[n] = 0; m_read[n] = 0; n_rdv[n] = 0;
    end
    s_waitrequest = 0; s_readdatavalid = 0; s_readdata = '0;
    n_sw = 0; n_acc_w = 0;
    @(posedge clk); #1;
    test_reset();
    test_solo_write();
    test_read_stall();
    test_tie(1);
    test_tie(0);
    test_reset_mid_read();
    test_write_stall_single();
    test_random(0);
    test_random(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
